// File: rtl/countdown_timer_if.sv
// Control and status bundle of the two-digit BCD countdown timer.
// The game side (master) drives the controls and the divider tick;
// the timer (slave) returns the remaining seconds and status flags.
interface countdown_timer_if;
    logic       tick_in;
    logic       start;
    logic       pause;
    logic       clear;
    logic       load_en;
    logic [7:0] load_val;
    logic [7:0] sec_bcd;
    logic       busy;
    logic       paused;
    logic       timeout;
    logic       expired;

    modport master (
        output tick_in, start, pause, clear, load_en, load_val,
        input  sec_bcd, busy, paused, timeout, expired
    );

    modport slave (
        input  tick_in, start, pause, clear, load_en, load_val,
        output sec_bcd, busy, paused, timeout, expired
    );
endinterface

// File: rtl/countdown_timer.sv
// Two-digit BCD seconds countdown timer.
// tick_in is the divider's slow square wave: it is synchronised into the
// clk domain as data, its rising edges are prescaled into one-second
// steps, and the remaining count is presented in BCD for the display.
module countdown_timer #(
    parameter int TICKS_PER_SEC = 100,
    parameter int SUB_W         = 8
) (
    input  logic            clk,
    input  logic            rst,
    countdown_timer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICKS_PER_SEC - 1);
    localparam logic [SUB_W-1:0] SUB_ONE = SUB_W'(1);

    // Clamp each BCD digit to 9 so an out-of-range preset stays displayable.
    function automatic logic [7:0] bcd_clamp(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
        ones = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
        return {tens, ones};
    endfunction

    // One-second BCD decrement with borrow; saturates at 00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = 8'h00;
        end else if (v[3:0] != 4'd0) begin
            r = {v[7:4], v[3:0] - 4'd1};
        end else begin
            r = {v[7:4] - 4'd1, 4'd9};
        end
        return r;
    endfunction

    logic          s1_r, s2_r, s3_r;
    logic          tick_rise_s;
    state_t        state_r, state_n_s;
    logic [SUB_W-1:0] sub_r, sub_n_s;
    logic [7:0]    sec_r, sec_n_s;
    logic          timeout_r, timeout_n_s;
    logic          busy_r, paused_r, expired_r;

    assign tick_rise_s = s2_r & ~s3_r;

    // Three-flop synchroniser on the asynchronous divider output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= bus.tick_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Next-state, count and pulse decisions; clear beats load beats start/pause beats tick.
    always_comb begin
        state_n_s   = state_r;
        sub_n_s     = sub_r;
        sec_n_s     = sec_r;
        timeout_n_s = 1'b0;
        if (bus.clear) begin
            state_n_s = ST_IDLE;
            sub_n_s   = '0;
            sec_n_s   = 8'h00;
        end else if (bus.load_en && ((state_r == ST_IDLE) || (state_r == ST_EXPIRED))) begin
            state_n_s = ST_IDLE;
            sub_n_s   = '0;
            sec_n_s   = bcd_clamp(bus.load_val);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start && (sec_r != 8'h00)) begin
                        state_n_s = ST_RUN;
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // A pause discards any tick landing in the same cycle.
                    if (bus.pause) begin
                        state_n_s = ST_PAUSE;
                    end else if (tick_rise_s) begin
                        if (sub_r == SUB_MAX) begin
                            sub_n_s = '0;
                            sec_n_s = bcd_dec(sec_r);
                            if (sec_r == 8'h01) begin
                                state_n_s   = ST_EXPIRED;
                                timeout_n_s = 1'b1;
                            end else begin
                                state_n_s = ST_RUN;
                            end
                        end else begin
                            sub_n_s = sub_r + SUB_ONE;
                        end
                    end else begin
                        state_n_s = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (bus.pause || bus.start) begin
                        state_n_s = ST_RUN;
                    end else begin
                        state_n_s = ST_PAUSE;
                    end
                end
                ST_EXPIRED: begin
                    state_n_s = ST_EXPIRED;
                end
                default: begin
                    state_n_s = ST_IDLE;
                    sub_n_s   = '0;
                    sec_n_s   = 8'h00;
                end
            endcase
        end
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            sub_r     <= '0;
            sec_r     <= 8'h00;
            timeout_r <= 1'b0;
            busy_r    <= 1'b0;
            paused_r  <= 1'b0;
            expired_r <= 1'b0;
        end else begin
            state_r   <= state_n_s;
            sub_r     <= sub_n_s;
            sec_r     <= sec_n_s;
            timeout_r <= timeout_n_s;
            busy_r    <= (state_n_s == ST_RUN) || (state_n_s == ST_PAUSE);
            paused_r  <= (state_n_s == ST_PAUSE);
            expired_r <= (state_n_s == ST_EXPIRED);
        end
    end

    assign bus.sec_bcd = sec_r;
    assign bus.busy    = busy_r;
    assign bus.paused  = paused_r;
    assign bus.timeout = timeout_r;
    assign bus.expired = expired_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances (4 and 1 ticks per second)
// receive identical stimulus and are compared against a seconds-level
// behavioural model after every operation.
module tb_countdown_timer;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    countdown_timer_if ifa ();
    countdown_timer_if ifb ();

    countdown_timer #(.TICKS_PER_SEC(4), .SUB_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    countdown_timer #(.TICKS_PER_SEC(1), .SUB_W(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: whole seconds as integers, one entry per instance.
    // mode: 0 idle, 1 counting, 2 paused, 3 expired
    int m_sec  [2];
    int m_sub  [2];
    int m_mode [2];
    int m_to   [2];
    int m_tps  [2];
    int to_cnt [2];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    // Count timeout cycles and require 00 on the display whenever it fires.
    always @(negedge clk) begin
        if (ifa.timeout === 1'b1) begin
            to_cnt[0]++;
            check_val("to_sec_a", {24'd0, ifa.sec_bcd}, 32'h0);
        end
        if (ifb.timeout === 1'b1) begin
            to_cnt[1]++;
            check_val("to_sec_b", {24'd0, ifb.sec_bcd}, 32'h0);
        end
    end

    function automatic int digit_clamp(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_sec[i]  = 0;
            m_sub[i]  = 0;
            m_mode[i] = 0;
        end
    endtask

    task automatic model_ctrl(input bit st, input bit pa, input bit cl, input bit ld, input logic [7:0] lv);
        for (int i = 0; i < 2; i++) begin
            if (cl) begin
                m_mode[i] = 0; m_sec[i] = 0; m_sub[i] = 0;
            end else if (ld && (m_mode[i] == 0 || m_mode[i] == 3)) begin
                m_sec[i]  = digit_clamp(int'(lv[7:4])) * 10 + digit_clamp(int'(lv[3:0]));
                m_sub[i]  = 0;
                m_mode[i] = 0;
            end else if (m_mode[i] == 0) begin
                if (st && m_sec[i] != 0) m_mode[i] = 1;
            end else if (m_mode[i] == 1) begin
                if (pa) m_mode[i] = 2;
            end else if (m_mode[i] == 2) begin
                if (pa || st) m_mode[i] = 1;
            end
        end
    endtask

    task automatic model_tick();
        for (int i = 0; i < 2; i++) begin
            if (m_mode[i] == 1) begin
                m_sub[i]++;
                if (m_sub[i] == m_tps[i]) begin
                    m_sub[i] = 0;
                    m_sec[i]--;
                    if (m_sec[i] == 0) begin
                        m_mode[i] = 3;
                        m_to[i]++;
                    end
                end
            end
        end
    endtask

    task automatic check_inst(input int i, input logic [7:0] sec, input logic bsy,
                              input logic psd, input logic exd, input logic to_now);
        logic [7:0] exp_bcd;
        exp_bcd = 8'((m_sec[i] / 10) * 16 + (m_sec[i] % 10));
        check_val($sformatf("sec%0d", i),     {24'd0, sec}, {24'd0, exp_bcd});
        check_val($sformatf("busy%0d", i),    {31'd0, bsy}, {31'd0, (m_mode[i] == 1 || m_mode[i] == 2)});
        check_val($sformatf("paused%0d", i),  {31'd0, psd}, {31'd0, (m_mode[i] == 2)});
        check_val($sformatf("expired%0d", i), {31'd0, exd}, {31'd0, (m_mode[i] == 3)});
        check_val($sformatf("to_now%0d", i),  {31'd0, to_now}, 32'd0);
        check_val($sformatf("to_cnt%0d", i),  32'(to_cnt[i]), 32'(m_to[i]));
    endtask

    task automatic check_all();
        @(negedge clk);
        check_inst(0, ifa.sec_bcd, ifa.busy, ifa.paused, ifa.expired, ifa.timeout);
        check_inst(1, ifb.sec_bcd, ifb.busy, ifb.paused, ifb.expired, ifb.timeout);
    endtask

    task automatic set_ctrl(input bit st, input bit pa, input bit cl, input bit ld, input logic [7:0] lv);
        ifa.start = st; ifa.pause = pa; ifa.clear = cl; ifa.load_en = ld; ifa.load_val = lv;
        ifb.start = st; ifb.pause = pa; ifb.clear = cl; ifb.load_en = ld; ifb.load_val = lv;
    endtask

    // One-cycle control pulse applied to both instances.
    task automatic ctrl(input bit st, input bit pa, input bit cl, input bit ld, input logic [7:0] lv);
        @(posedge clk); #1;
        set_ctrl(st, pa, cl, ld, lv);
        @(posedge clk); #1;
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        model_ctrl(st, pa, cl, ld, lv);
        check_all();
    endtask

    // One full tick_in period, long enough for the synchroniser to settle.
    task automatic tick_edge(input bit do_check);
        @(posedge clk); #3;
        ifa.tick_in = 1'b1; ifb.tick_in = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        ifa.tick_in = 1'b0; ifb.tick_in = 1'b0;
        repeat (4) @(posedge clk);
        model_tick();
        if (do_check) check_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick_edge(1'b0);
        check_all();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lv;
        int         r;
        n_total = 0; n_bad = 0;
        m_tps[0] = 4; m_tps[1] = 1;
        m_to[0] = 0; m_to[1] = 0;
        to_cnt[0] = 0; to_cnt[1] = 0;
        model_reset();
        ifa.tick_in = 1'b0; ifb.tick_in = 1'b0;
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        check_all();
        #2 rst = 1'b0;
        check_all();

        // Expiry: 02 down to 00 with 4 ticks per second on instance a
        ctrl(1'b0, 1'b0, 1'b0, 1'b1, 8'h02);
        ctrl(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check_val("exp_02", {24'd0, ifa.sec_bcd}, 32'h02);
        ticks(4);
        check_val("exp_01", {24'd0, ifa.sec_bcd}, 32'h01);
        ticks(4);
        check_val("exp_00", {24'd0, ifa.sec_bcd}, 32'h00);
        check_val("exp_flag", {31'd0, ifa.expired}, 32'd1);
        check_val("exp_pulses", 32'(to_cnt[0]), 32'd1);
        // start/pause/ticks ignored while expired
        ctrl(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        ticks(2);

        // BCD borrow on instance b and digit clamp on load
        ctrl(1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
        ctrl(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        ticks(1);
        check_val("borrow_b", {24'd0, ifb.sec_bcd}, 32'h09);
        ctrl(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        ctrl(1'b0, 1'b0, 1'b0, 1'b1, 8'hA7);
        check_val("clamp", {24'd0, ifa.sec_bcd}, 32'h97);

        // Pause holds the count; resume continues from held sub count
        ctrl(1'b0, 1'b0, 1'b0, 1'b1, 8'h05);
        ctrl(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        ticks(2);
        ctrl(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        ticks(10);
        check_val("pause_hold", {24'd0, ifa.sec_bcd}, 32'h05);
        check_val("pause_flag", {31'd0, ifa.paused}, 32'd1);
        ctrl(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        ticks(2);
        check_val("resume", {24'd0, ifa.sec_bcd}, 32'h04);

        // Load ignored while running; start+pause in RUN pauses
        ctrl(1'b0, 1'b0, 1'b0, 1'b1, 8'h30);
        check_val("load_run", {24'd0, ifa.sec_bcd}, 32'h04);
        ctrl(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check_val("st_pa", {31'd0, ifa.paused}, 32'd1);

        // start in IDLE at 00 is ignored
        ctrl(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        ctrl(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check_val("start_00", {31'd0, ifa.busy}, 32'd0);

        // clear wins over load in EXPIRED
        ctrl(1'b0, 1'b0, 1'b0, 1'b1, 8'h01);
        ctrl(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        ticks(4);
        ctrl(1'b0, 1'b0, 1'b1, 1'b1, 8'h55);
        check_val("clr_ld", {24'd0, ifa.sec_bcd}, 32'h00);

        // Asynchronous reset mid-count at 07
        ctrl(1'b0, 1'b0, 1'b0, 1'b1, 8'h08);
        ctrl(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        ticks(6);
        check_val("pre_rst", {24'd0, ifa.sec_bcd}, 32'h07);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check_val("rst_sec", {24'd0, ifa.sec_bcd}, 32'h0);
        check_val("rst_stat", {28'd0, ifa.busy, ifa.paused, ifa.timeout, ifa.expired}, 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        ticks(5);

        // Randomised operations against the model
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 11);
            if (r < 6) begin
                tick_edge(1'b1);
            end else if (r == 6) begin
                ctrl(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            end else if (r == 7) begin
                ctrl(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            end else if (r == 8 || r == 9) begin
                lv = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(1, 3));
                ctrl(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1, lv);
            end else if (r == 10) begin
                ctrl(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
            end else begin
                ctrl(1'b0, 1'b0, 1'($urandom_range(0, 3) == 0), 1'b0, 8'h00);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

- Two-digit BCD seconds countdown timer for the guess-number game.
- Sits directly downstream of the board frequency divider:
  - takes the divider's slow square-wave output as a plain data input (`tick_in`), not as a clock;
  - synchronises it into the system clock domain and prescales its rising edges into one-second steps.
- Exposes the remaining seconds for the seven-segment display and a timeout pulse for the game controller.

## Interface

Parameters:
- `TICKS_PER_SEC`, default 100: `tick_in` rising edges per second; legal range 1-255.
- `SUB_W`, default 8: width of the sub-second counter; must hold `TICKS_PER_SEC-1`.

Ports:
- `clk`  input  1  system clock; everything is synchronous to its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `tick_in`  input  1  slow square wave from the frequency divider; asynchronous to logic use.
- `start`  input  1  level sampled each cycle; begins or resumes counting.
- `pause`  input  1  single-cycle request; toggles RUN and PAUSE.
- `clear`  input  1  synchronous abort to IDLE with 00.
- `load_en`  input  1  loads `load_val`.
- `load_val`  input  8  BCD preset: [7:4] tens, [3:0] ones.
- `sec_bcd`  output  8  remaining seconds in BCD; registered.
- `busy`  output  1  high in RUN or PAUSE.
- `paused`  output  1  high in PAUSE.
- `timeout`  output  1  one-cycle pulse when the count reaches 00 from RUN.
- `expired`  output  1  level; high in EXPIRED.

## Operation

- Synchroniser: three-flop chain `s1` → `s2` → `s3` on `tick_in`.
  - `tick_rise = s2 & ~s3`: exactly one `clk` cycle per `tick_in` rising edge.
- States: IDLE, RUN, PAUSE, EXPIRED. Transition priority is `clear` > `load_en` > `start`/`pause` > tick.
- `clear` (any state):
  - go to IDLE; `sec_bcd` = 00; sub counter = 0; `expired` = 0.
- `load_en`:
  - Honoured only in IDLE and EXPIRED; ignored in RUN and PAUSE.
  - Loads `sec_bcd` from `load_val` with each digit clamped to 9 if above 9 (e.g. 8'hA7 → 8'h97).
  - Sub counter = 0; next state IDLE.
- IDLE:
  - `start` with `sec_bcd` ≠ 00 → RUN.
  - `start` with `sec_bcd` = 00 is ignored.
  - `pause` is ignored.
- RUN:
  - Each `tick_rise` increments the sub counter.
  - On `tick_rise` with sub counter = `TICKS_PER_SEC-1`: sub counter → 0 and `sec_bcd` decrements.
  - `pause` → PAUSE. If `start` and `pause` are both high, `pause` wins.
- PAUSE:
  - Sub counter and `sec_bcd` hold; ticks are ignored.
  - `pause` or `start` → RUN, continuing from the held sub count.
- BCD decrement:
  - ones ≠ 0: ones − 1.
  - ones = 0: ones = 9 and tens − 1 (e.g. 8'h40 → 8'h39).
  - Never wraps below 00.
- Expiry: the decrement from 01 to 00 moves the state to EXPIRED.
  - `timeout` = 1 for that one cycle; `expired` = 1 until `clear` or `load_en`.
  - `start`, `pause` and ticks are ignored in EXPIRED.
- Ticks arriving in IDLE or EXPIRED are ignored and do not advance the sub counter.

## Timing

- Reset values (asynchronous on `rst` high):
  - state IDLE, `sec_bcd` = 00, sub counter 0, `s1`/`s2`/`s3` = 0;
  - `busy`, `paused`, `timeout`, `expired` all 0.
- Reset asserted mid-count aborts immediately; there is no resume after reset release.
- Synchroniser latency: `tick_rise` is high 2-3 `clk` cycles after `tick_in` rises.
- Control latency: `sec_bcd` and the state update on the `clk` edge ending the cycle in which `tick_rise` (or the control input) is high. All outputs are registered.
- `timeout` is asserted in the same cycle that `sec_bcd` first reads 00.
- Both `busy` and `paused` are derived from registered state, so they change together with it.
- A `tick_rise` in the same cycle as `pause` in RUN is discarded: the pause takes effect first.

## Test plan

- **Expiry:** `TICKS_PER_SEC`=4, `load_val`=8'h02, `start`, then 8 `tick_in` edges → `sec_bcd` reads 02, 01 (after 4 edges), 00 (after 8); one-cycle `timeout`; `expired`=1; `busy`=0.
- **BCD borrow:** `TICKS_PER_SEC`=1, load 8'h10, run 1 edge → 8'h09. Load 8'hA7 in IDLE → `sec_bcd`=8'h97.
- **Pause:** load 8'h05, run 2 edges (`TICKS_PER_SEC`=4), `pause`, 10 edges → `sec_bcd` still 05 and `paused`=1. `start`, then 2 more edges → 04.
- **Ignored loads and starts:** `load_en` with 8'h30 during RUN → `sec_bcd` unchanged. `start` in IDLE with 00 → stays IDLE, `busy`=0.
- **Clear and simultaneous inputs:** `clear` asserted together with `load_en` in EXPIRED → IDLE, 00, `expired`=0. `start` with `pause` in RUN → PAUSE.
- **Reset:** `rst` pulsed mid-count at `sec_bcd`=8'h07 → all outputs 0 asynchronously. After release, 5 `tick_in` edges cause no change.
